// File: rtl/fifo_mon_pkg.sv
// fifo_mon_pkg: shared types and helpers for the FIFO protocol monitor
package fifo_mon_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, OVF = 2'd1, UDF = 2'd2, MIS = 2'd3} err_type_e;
  typedef enum logic {ST_OK = 1'b0, ST_FAULT = 1'b1} ch_state_e;
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_mon_channel.sv
// fifo_mon_channel: shadow occupancy, high-water, fault FSM and sticky errors for one FIFO
module fifo_mon_channel
  import fifo_mon_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int OCC_W = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic             wr_full,
  input  logic             rd_en,
  input  logic             rd_empty,
  output logic [OCC_W-1:0] occ,
  output logic [OCC_W-1:0] hw,
  output logic             ovf,
  output logic             udf,
  output logic             mis,
  output logic             mis_rise,
  output logic             err_ovf,
  output logic             err_udf,
  output logic             err_mis,
  output logic             fault_nxt
);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);
  ch_state_e state, state_nxt;
  logic mis_q, acc_wr, acc_rd;
  logic [OCC_W-1:0] occ_nxt;
  always_comb begin
    acc_wr = wr_en & ~wr_full;
    acc_rd = rd_en & ~rd_empty;
    ovf = wr_en & wr_full;
    udf = rd_en & rd_empty;
    mis = (wr_full != (occ == FULL)) | (rd_empty != (occ == '0));
    mis_rise = mis & ~mis_q;
    occ_nxt = (acc_wr && !acc_rd && occ != FULL) ? occ + OCC_W'(1) :
              (acc_rd && !acc_wr && occ != '0) ? occ - OCC_W'(1) : occ;
    state_nxt = (ovf | udf | mis) ? ST_FAULT : clr ? ST_OK : state;
    fault_nxt = state_nxt == ST_FAULT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OK;
      occ <= '0;
      hw <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
      err_mis <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      state <= state_nxt;
      occ <= occ_nxt;
      hw <= (clr || occ_nxt > hw) ? occ_nxt : hw;
      err_ovf <= (err_ovf & ~clr) | ovf;
      err_udf <= (err_udf & ~clr) | udf;
      err_mis <= (err_mis & ~clr) | mis;
      mis_q <= mis;
    end
  end
endmodule

// File: rtl/fifo_protocol_monitor.sv
// fifo_protocol_monitor: multi-channel FIFO handshake checker with counters, first-error capture and irq
module fifo_protocol_monitor
  import fifo_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  localparam int OCC_W = occ_width(DEPTH),
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       wr_en,
  input  logic [NUM_CH-1:0]       wr_full,
  input  logic [NUM_CH-1:0]       rd_en,
  input  logic [NUM_CH-1:0]       rd_empty,
  input  logic                    clr_err,
  output logic [NUM_CH*OCC_W-1:0] occupancy,
  output logic [NUM_CH*OCC_W-1:0] high_water,
  output logic [NUM_CH-1:0]       err_overflow,
  output logic [NUM_CH-1:0]       err_underflow,
  output logic [NUM_CH-1:0]       err_flag_mismatch,
  output logic [CNT_W-1:0]        viol_count,
  output logic                    first_err_vld,
  output logic [CH_W-1:0]         first_err_ch,
  output logic [1:0]              first_err_type,
  output logic                    irq
);
  localparam int SUM_W = CNT_W + 8;
  localparam logic [SUM_W-1:0] SAT = SUM_W'({CNT_W{1'b1}});
  logic [NUM_CH-1:0] ovf, udf, mis, mis_rise, fault_nxt;
  logic [7:0] pop;
  logic [SUM_W-1:0] sum;
  logic [CH_W-1:0] sel_ch;
  err_type_e sel_type;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fifo_mon_channel #(.DEPTH(DEPTH), .OCC_W(OCC_W)) u_ch (
      .clk(clk),
      .rst(rst),
      .clr(clr_err),
      .wr_en(wr_en[i]),
      .wr_full(wr_full[i]),
      .rd_en(rd_en[i]),
      .rd_empty(rd_empty[i]),
      .occ(occupancy[i*OCC_W +: OCC_W]),
      .hw(high_water[i*OCC_W +: OCC_W]),
      .ovf(ovf[i]),
      .udf(udf[i]),
      .mis(mis[i]),
      .mis_rise(mis_rise[i]),
      .err_ovf(err_overflow[i]),
      .err_udf(err_underflow[i]),
      .err_mis(err_flag_mismatch[i]),
      .fault_nxt(fault_nxt[i])
    );
  end
  // Descending scan so the lowest-indexed faulting channel is the one left selected
  always_comb begin
    pop = '0;
    sel_ch = '0;
    sel_type = NONE;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      pop = pop + 8'(ovf[i]) + 8'(udf[i]) + 8'(mis_rise[i]);
      if (ovf[i] | udf[i] | mis[i]) begin
        sel_ch = CH_W'(i);
        sel_type = mis[i] ? MIS : udf[i] ? UDF : OVF;
      end
    end
    sum = SUM_W'(clr_err ? '0 : viol_count) + SUM_W'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      viol_count <= '0;
      first_err_vld <= 1'b0;
      first_err_ch <= '0;
      first_err_type <= '0;
      irq <= 1'b0;
    end else begin
      viol_count <= sum > SAT ? SAT[CNT_W-1:0] : sum[CNT_W-1:0];
      irq <= |fault_nxt;
      if (clr_err || !first_err_vld) begin
        first_err_vld <= sel_type != NONE;
        first_err_ch <= sel_ch;
        first_err_type <= sel_type;
      end
    end
  end
endmodule

// File: tb/tb_fifo_protocol_monitor.sv
// tb_fifo_protocol_monitor: vector table, directed corner cases and random traffic against a reference model
module tb_fifo_protocol_monitor;
  localparam int NC = 4;
  localparam int D = 16;
  localparam int CW = 4;
  localparam int OW = $clog2(D + 1);
  localparam int SATV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, clr_err;
  logic [NC-1:0] wr_en, wr_full, rd_en, rd_empty;
  logic [NC*OW-1:0] occupancy, high_water;
  logic [NC-1:0] err_overflow, err_underflow, err_flag_mismatch;
  logic [CW-1:0] viol_count;
  logic first_err_vld;
  logic [1:0] first_err_ch;
  logic [1:0] first_err_type;
  logic irq;

  fifo_protocol_monitor #(.NUM_CH(NC), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_full(wr_full), .rd_en(rd_en),
    .rd_empty(rd_empty), .clr_err(clr_err), .occupancy(occupancy),
    .high_water(high_water), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_flag_mismatch(err_flag_mismatch),
    .viol_count(viol_count), .first_err_vld(first_err_vld),
    .first_err_ch(first_err_ch), .first_err_type(first_err_type), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_occ[NC], m_hw[NC];
  bit m_ovf[NC], m_udf[NC], m_mis[NC], m_prev[NC];
  int m_cnt, m_ch, m_type;
  bit m_vld, m_irq;

  typedef struct {
    logic r, c;
    logic [3:0] we, wf, re, ree;
    int occ0, viol, irq, fvld, fch, ftype;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [3:0] fullv();
    logic [3:0] v;
    for (int i = 0; i < NC; i++) v[i] = m_occ[i] == D;
    return v;
  endfunction

  function automatic logic [3:0] emptyv();
    logic [3:0] v;
    for (int i = 0; i < NC; i++) v[i] = m_occ[i] == 0;
    return v;
  endfunction

  task automatic model(input logic r, input logic c, input logic [3:0] we, wf, re, ree);
    bit o[NC], u[NC], mm[NC];
    int add, d;
    if (r) begin
      for (int i = 0; i < NC; i++) begin
        m_occ[i] = 0; m_hw[i] = 0; m_ovf[i] = 0; m_udf[i] = 0; m_mis[i] = 0; m_prev[i] = 0;
      end
      m_cnt = 0; m_vld = 0; m_ch = 0; m_type = 0; m_irq = 0;
      return;
    end
    add = 0;
    m_irq = 0;
    for (int i = 0; i < NC; i++) begin
      o[i] = we[i] && wf[i];
      u[i] = re[i] && ree[i];
      mm[i] = (wf[i] != (m_occ[i] == D)) || (ree[i] != (m_occ[i] == 0));
      add += int'(o[i]) + int'(u[i]) + int'(mm[i] && !m_prev[i]);
      m_prev[i] = mm[i];
      d = 0;
      if (we[i] && !wf[i]) d++;
      if (re[i] && !ree[i]) d--;
      m_occ[i] += d;
      if (m_occ[i] > D) m_occ[i] = D;
      if (m_occ[i] < 0) m_occ[i] = 0;
      m_hw[i] = (c || m_occ[i] > m_hw[i]) ? m_occ[i] : m_hw[i];
      if (c) begin m_ovf[i] = 0; m_udf[i] = 0; m_mis[i] = 0; end
      m_ovf[i] |= o[i];
      m_udf[i] |= u[i];
      m_mis[i] |= mm[i];
      m_irq |= m_ovf[i] | m_udf[i] | m_mis[i];
    end
    m_cnt = (c ? 0 : m_cnt) + add;
    if (m_cnt > SATV) m_cnt = SATV;
    if (c) begin m_vld = 0; m_ch = 0; m_type = 0; end
    if (!m_vld)
      for (int i = 0; i < NC; i++)
        if (o[i] || u[i] || mm[i]) begin
          m_vld = 1;
          m_ch = i;
          m_type = mm[i] ? 3 : u[i] ? 2 : 1;
          break;
        end
  endtask

  task automatic check_model();
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("occupancy[%0d]", i), occupancy[i*OW +: OW], m_occ[i]);
      chk($sformatf("high_water[%0d]", i), high_water[i*OW +: OW], m_hw[i]);
      chk($sformatf("err_overflow[%0d]", i), err_overflow[i], m_ovf[i]);
      chk($sformatf("err_underflow[%0d]", i), err_underflow[i], m_udf[i]);
      chk($sformatf("err_flag_mismatch[%0d]", i), err_flag_mismatch[i], m_mis[i]);
    end
    chk("viol_count", viol_count, m_cnt);
    chk("first_err_vld", first_err_vld, m_vld);
    chk("first_err_ch", first_err_ch, m_ch);
    chk("first_err_type", first_err_type, m_type);
    chk("irq", irq, m_irq);
  endtask

  task automatic apply(input logic r, input logic c, input logic [3:0] we, wf, re, ree);
    rst = r; clr_err = c; wr_en = we; wr_full = wf; rd_en = re; rd_empty = ree;
    @(posedge clk);
    model(r, c, we, wf, re, ree);
    #1;
    check_model();
  endtask

  task automatic idle(input logic c);
    apply(1'b0, c, 4'h0, fullv(), 4'h0, emptyv());
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'hF, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'hE, 2, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 4'h1, 4'h0, 4'h1, 4'hE, 2, 0, 0, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 4'hE, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 4'hE, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h2, 4'hF, 0, 1, 1, 1, 1, 2};
    tbl[7]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 4'hF, 0, 2, 1, 1, 1, 2};
    tbl[8]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h7, 0, 1, 1, 1, 3, 3};
    tbl[10] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h7, 0, 1, 1, 1, 3, 3};
    tbl[11] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{1'b1, 1'b0, 4'h1, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 4'hF, 0, 1, 1, 1, 0, 3};
    tbl[15] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{1'b0, 1'b0, 4'h0, 4'h2, 4'h2, 4'hF, 0, 2, 1, 1, 1, 3};
    tbl[17] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0, 0, 0};

    apply(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
    apply(1'b1, 1'b0, 4'hF, 4'hF, 4'hF, 4'h0);

    for (int k = 0; k < 18; k++) begin
      apply(tbl[k].r, tbl[k].c, tbl[k].we, tbl[k].wf, tbl[k].re, tbl[k].ree);
      chk($sformatf("tbl%0d occ0", k), occupancy[OW-1:0], tbl[k].occ0);
      chk($sformatf("tbl%0d viol", k), viol_count, tbl[k].viol);
      chk($sformatf("tbl%0d irq", k), irq, tbl[k].irq);
      chk($sformatf("tbl%0d fvld", k), first_err_vld, tbl[k].fvld);
      chk($sformatf("tbl%0d fch", k), first_err_ch, tbl[k].fch);
      chk($sformatf("tbl%0d ftype", k), first_err_type, tbl[k].ftype);
    end

    for (int k = 0; k < 16; k++) apply(1'b0, 1'b0, 4'h1, fullv(), 4'h0, emptyv());
    chk("fill occ0", occupancy[OW-1:0], 16);
    chk("fill hw0", high_water[OW-1:0], 16);
    for (int k = 0; k < 16; k++) apply(1'b0, 1'b0, 4'h0, fullv(), 4'h1, emptyv());
    chk("drain occ0", occupancy[OW-1:0], 0);
    chk("drain hw0", high_water[OW-1:0], 16);
    chk("drain errs", {err_overflow, err_underflow, err_flag_mismatch}, 0);
    chk("drain irq", irq, 0);

    for (int k = 0; k < 16; k++) apply(1'b0, 1'b0, 4'hC, fullv(), 4'h0, emptyv());
    apply(1'b0, 1'b0, 4'h4, fullv(), 4'h0, emptyv());
    chk("ovf2 err", err_overflow[2], 1);
    chk("ovf2 viol", viol_count, 1);
    chk("ovf2 fch", first_err_ch, 2);
    chk("ovf2 ftype", first_err_type, 1);
    chk("ovf2 irq", irq, 1);
    chk("ovf2 occ2", occupancy[2*OW +: OW], 16);
    idle(1'b1);
    chk("clr irq", irq, 0);
    apply(1'b0, 1'b0, 4'h8, fullv(), 4'h2, emptyv());
    chk("tie fch", first_err_ch, 1);
    chk("tie ftype", first_err_type, 2);
    chk("tie viol", viol_count, 2);
    idle(1'b1);

    for (int k = 0; k < 3; k++) apply(1'b0, 1'b0, 4'h0, fullv(), 4'h0, emptyv() & 4'hD);
    chk("mis1 err", err_flag_mismatch[1], 1);
    chk("mis1 viol", viol_count, 1);
    idle(1'b1);

    for (int k = 0; k < 20; k++) apply(1'b0, 1'b0, 4'h4, fullv(), 4'h0, emptyv());
    chk("sat viol", viol_count, SATV);
    apply(1'b0, 1'b1, 4'h0, fullv(), 4'h1, emptyv());
    chk("clrev udf0", err_underflow[0], 1);
    chk("clrev ovf2", err_overflow[2], 0);
    chk("clrev viol", viol_count, 1);
    chk("clrev ftype", first_err_type, 2);
    chk("clrev fch", first_err_ch, 0);
    idle(1'b1);

    for (int k = 0; k < 7; k++) apply(1'b0, 1'b0, 4'h1, fullv(), 4'h0, emptyv());
    chk("pre-rst occ0", occupancy[OW-1:0], 7);
    apply(1'b1, 1'b0, 4'h5, fullv(), 4'h2, emptyv());
    chk("rst all", {occupancy, high_water, err_overflow, err_underflow, err_flag_mismatch,
                    viol_count, first_err_vld, first_err_ch, first_err_type, irq}, 0);
    idle(1'b0);
    chk("post-rst viol", viol_count, 0);
    chk("post-rst occ", occupancy, 0);

    for (int k = 0; k < 3000; k++) begin
      logic [3:0] wf, ree;
      wf = fullv();
      ree = emptyv();
      if ($urandom_range(0, 15) == 0) wf[$urandom_range(0, NC-1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) ree[$urandom_range(0, NC-1)] ^= 1'b1;
      apply($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0,
            4'($urandom), wf, 4'($urandom), ree);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
